uart_tx_fifo_drain: RTL and testbench
=====================================

// Module: uart_tx_fifo_drain
// PURPOSE
//  UART transmitter and the read-side client of the UART byte FIFO.
//  Pops one byte when the FIFO is non-empty and transmission is enabled.
//  Serialises the byte as start + DATA_BITS (LSB first) + optional parity + stop, paced by an external oversampling tick.
//  Sits between the TX FIFO (read_flag/data_out/empty_flag) and the tx pin.
// PARAMETERS
//  DATA_BITS   8   payload bits per frame (5..8)
//  OVERSAMPLE  16  baud_tick pulses per start/data/parity bit
//  STOP_TICKS  16  baud_tick pulses in stop period (16=1 stop bit, 32=2 stop bits)
//  PARITY      0   0=none, 1=even, 2=odd
// PORTS
//  clock         in   1          system clock, all logic on posedge
//  reset         in   1          synchronous, active-high
//  baud_tick     in   1          one-clock pulse at OVERSAMPLE x baud rate
//  tx_enable     in   1          permit start of a new frame
//  fifo_empty    in   1          FIFO empty_flag
//  fifo_data     in   DATA_BITS  FIFO data_out (registered, valid the cycle after a read)
//  fifo_read     out  1          FIFO read_flag, one-cycle registered pulse
//  tx            out  1          serial line, idle high
//  tx_busy       out  1          high in every state except IDLE
//  tx_done_tick  out  1          one-cycle pulse at end of stop period
// BEHAVIOUR
//  Reset (sync): state=IDLE; tx=1; fifo_read=0; tx_busy=0; tx_done_tick=0; counters and shift register=0.
//  Reset mid-frame: frame aborts; tx=1 from the next edge; no further FIFO read.
//  FSM (all outputs registered):
//   IDLE:   if tx_enable && !fifo_empty -> fifo_read<=1, go FETCH; else hold, tx=1.
//   FETCH:  fifo_read<=0, go LOAD. The FIFO updates data_out at this edge.
//   LOAD:   shreg<=fifo_data, parity bit computed from fifo_data, tick_cnt<=0, tx<=0, go START.
//   START:  on each baud_tick tick_cnt++; at tick OVERSAMPLE-1: tick_cnt<=0, bit_cnt<=0, tx<=shreg[0], go DATA.
//   DATA:   after OVERSAMPLE ticks, shift right. If bit_cnt==DATA_BITS-1, go PARITY (if PARITY!=0) or STOP; else bit_cnt++.
//   PARITY: tx=even (^data) or odd (~^data) for OVERSAMPLE ticks, then go STOP.
//   STOP:   tx=1 for STOP_TICKS ticks; on last tick tx_done_tick<=1, go IDLE.
//  Latency: fifo_read pulse to tx falling edge = 2 clocks.
//  Back-to-back frames: IDLE re-evaluates the cycle after STOP. The gap between a stop bit and the next start is 3 clocks, not ticks.
//  baud_tick is ignored in IDLE/FETCH/LOAD. It does not need to be phase-aligned to the frame.
//  tx_enable is sampled only in IDLE. Deassertion mid-frame lets the frame complete.
//  fifo_empty is sampled only in IDLE. Exactly one fifo_read per frame; never read when empty.
//  Widths: tick_cnt = clog2(max(OVERSAMPLE,STOP_TICKS)) bits; bit_cnt = clog2(DATA_BITS) bits; no wrap inside a state.
// STRUCTURE
//  Shared package/include: state encodings (IDLE..STOP), PARITY_NONE/EVEN/ODD constants, clog2 function.
//  Flat single module, no sub-module. The baud tick generator stays outside and is shared with the receiver.
// TESTING
//  (OVERSAMPLE=16, baud_tick every 4 clocks => 64 clocks per bit)
//  1) Reset held 3 cycles mid-DATA -> tx=1, busy=0, fifo_read=0 next cycle; no extra read after release.
//  2) FIFO holds 0x55, tx_enable=1 -> fifo_read pulses 1 cycle; tx=0 two clocks later; then 1,0,1,0,1,0,1,0 each 64 clocks; stop=1; done pulse; 640 clocks total.
//  3) Empty FIFO, tx_enable=1 for 1000 clocks -> fifo_read never asserts; tx stays 1.
//  4) Three bytes 0x00, 0xFF, 0xA3 queued -> three fifo_read pulses, three frames in order, 3-clock inter-frame gaps, three done ticks.
//  5) PARITY=1, byte 0x07 -> parity bit 1; PARITY=2, byte 0x07 -> parity bit 0; frame = 11 bits.
//  6) tx_enable dropped mid-DATA with bytes still queued -> current frame completes; no new fifo_read until tx_enable is re-asserted.

Source files
------------

// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the UART transmitter and its FIFO drain logic.
// State encodings, parity mode constants and a width helper.
package uart_tx_fifo_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops one byte per frame from the TX FIFO and serialises
// it as start + data (LSB first) + optional parity + stop, paced by baud_tick.
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16,
  parameter int PARITY     = PARITY_NONE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 tx_enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int TICK_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int TW       = clog2(TICK_MAX);
  localparam int BW       = clog2(DATA_BITS);

  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_d, read_d, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      tx           <= 1'b1;
      fifo_read    <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      tx           <= tx_d;
      fifo_read    <= read_d;
      tx_busy      <= (state_d != ST_IDLE);
      tx_done_tick <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx;
    read_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_enable && !fifo_empty) begin
          read_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      // FIFO presents the popped byte on data_out after this edge.
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shreg_d = fifo_data;
        par_d   = (PARITY == PARITY_ODD) ? ~^fifo_data : ^fifo_data;
        tick_d  = '0;
        tx_d    = 1'b0;
        state_d = ST_START;
      end
      ST_START: if (baud_tick) begin
        if (tick_q == OS_LAST) begin
          tick_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = ST_DATA;
        end else tick_d = tick_q + TW'(1);
      end
      ST_DATA: if (baud_tick) begin
        if (tick_q == OS_LAST) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
            if (PARITY != PARITY_NONE) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else tick_d = tick_q + TW'(1);
      end
      ST_PARITY: if (baud_tick) begin
        if (tick_q == OS_LAST) begin
          tick_d  = '0;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else tick_d = tick_q + TW'(1);
      end
      ST_STOP: if (baud_tick) begin
        if (tick_q == STOP_LAST) begin
          tick_d  = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else tick_d = tick_q + TW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: FIFO model, baud tick every 4 clocks,
// mid-bit sampling of tx frames, plus even/odd parity instances.
module tb_uart_tx_fifo_drain;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       tx_enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read, tx, tx_busy, tx_done_tick;

  logic       en_p = 1'b0;
  logic       empty_p = 1'b1;
  logic [7:0] data_p = 8'h07;
  logic       read_e, tx_e, busy_e, done_e;
  logic       read_o, tx_o, busy_o, done_o;

  logic [2:0] tx_all, done_all, busy_all;
  assign tx_all   = {tx_o, tx_e, tx};
  assign done_all = {done_o, done_e, tx_done_tick};
  assign busy_all = {busy_o, busy_e, tx_busy};

  uart_tx_fifo_drain #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_TICKS(16), .PARITY(0)) dut (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_enable(tx_enable),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
    .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick));

  uart_tx_fifo_drain #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_TICKS(16), .PARITY(1)) dut_even (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_enable(en_p),
    .fifo_empty(empty_p), .fifo_data(data_p), .fifo_read(read_e),
    .tx(tx_e), .tx_busy(busy_e), .tx_done_tick(done_e));

  uart_tx_fifo_drain #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_TICKS(16), .PARITY(2)) dut_odd (
    .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_enable(en_p),
    .fifo_empty(empty_p), .fifo_data(data_p), .fifo_read(read_o),
    .tx(tx_o), .tx_busy(busy_o), .tx_done_tick(done_o));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int bcnt = 0;
  always @(negedge clock) begin
    bcnt = (bcnt + 1) % 4;
    baud_tick = (bcnt == 0);
  end

  // FIFO model: data_out registered, updated on the edge after read_flag.
  logic [7:0] q[$];
  int underflow = 0;
  always @(posedge clock)
    if (fifo_read) begin
      if (q.size() == 0) underflow <= underflow + 1;
      else fifo_data <= q.pop_front();
    end
  always @(negedge clock) fifo_empty = (q.size() == 0);

  int reads = 0, run = 0, max_run = 0, last_read_cyc = 0;
  always @(negedge clock)
    if (fifo_read) begin
      reads++;
      run++;
      last_read_cyc = cyc;
      if (run > max_run) max_run = run;
    end else run = 0;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    total++;
    assert (v >= lo && v <= hi) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic wait_fall(input int sel, input string tag, output int fc);
    int n;
    n = 0;
    while (tx_all[sel] !== 1'b0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk_rng({tag, "_fall_wait"}, n, 0, 2999);
    fc = cyc;
  endtask

  // Samples each bit mid-period; the start bit may be up to 3 clocks short
  // because baud_tick is not phase-aligned to the frame.
  task automatic frame(input int sel, input logic [11:0] exp, input logic [11:0] exp2,
                       input int nb, input int drop_at, input string tag,
                       output int fc, output int dc);
    int n;
    wait_fall(sel, tag, fc);
    for (int i = 0; i < nb; i++) begin
      repeat ((i == 0) ? 32 : 64) @(negedge clock);
      chk($sformatf("%s_bit%0d", tag, i), tx_all[sel], exp[i]);
      if (sel == 1) chk($sformatf("%s_odd_bit%0d", tag, i), tx_all[2], exp2[i]);
      if (i == 0) chk({tag, "_busy"}, busy_all[sel], 1'b1);
      if (i == drop_at) tx_enable = 1'b0;
    end
    n = 0;
    while (done_all[sel] !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    dc = cyc;
    chk_rng({tag, "_len"}, dc - fc, nb * 64 - 3, nb * 64);
    @(negedge clock);
    chk({tag, "_done_width"}, done_all[sel], 1'b0);
  endtask

  function automatic logic [11:0] mk(input logic [7:0] b);
    logic [11:0] f;
    f = 12'hFFF;
    f[0] = 1'b0;
    f[8:1] = b;
    return f;
  endfunction

  initial begin
    int fc, dc, pd, r0, hi, n;
    repeat (3) @(negedge clock);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_read", fifo_read, 1'b0);
    chk("rst_done", tx_done_tick, 1'b0);
    chk("rst_tx_even", tx_e, 1'b1);
    reset = 1'b0;

    // single byte 0x55
    q.push_back(8'h55);
    r0 = reads;
    tx_enable = 1'b1;
    frame(0, mk(8'h55), 12'h0, 10, -1, "t2", fc, dc);
    chk("t2_reads", reads - r0, 1);
    chk("t2_read_to_fall", fc - last_read_cyc, 2);

    // empty FIFO with enable held
    r0 = reads;
    hi = 1;
    repeat (1000) begin
      @(negedge clock);
      if (tx !== 1'b1) hi = 0;
    end
    chk("t3_reads", reads - r0, 0);
    chk("t3_tx_high", hi, 1);
    chk("t3_busy", tx_busy, 1'b0);

    // three queued bytes back to back
    tx_enable = 1'b0;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'hA3);
    @(negedge clock);
    r0 = reads;
    tx_enable = 1'b1;
    frame(0, mk(8'h00), 12'h0, 10, -1, "t4a", fc, dc);
    pd = dc;
    frame(0, mk(8'hFF), 12'h0, 10, -1, "t4b", fc, dc);
    chk("t4_gap1", fc - pd, 3);
    pd = dc;
    frame(0, mk(8'hA3), 12'h0, 10, -1, "t4c", fc, dc);
    chk("t4_gap2", fc - pd, 3);
    chk("t4_reads", reads - r0, 3);

    // reset held 3 cycles mid-DATA
    q.push_back(8'h3C);
    r0 = reads;
    wait_fall(0, "t1", fc);
    repeat (200) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t1_tx", tx, 1'b1);
    chk("t1_busy", tx_busy, 1'b0);
    chk("t1_read", fifo_read, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (300) @(negedge clock);
    chk("t1_reads", reads - r0, 1);
    chk("t1_tx_idle", tx, 1'b1);
    chk("t1_busy_idle", tx_busy, 1'b0);

    // enable dropped mid-DATA with a byte still queued
    tx_enable = 1'b0;
    q.push_back(8'h96);
    q.push_back(8'h5A);
    @(negedge clock);
    r0 = reads;
    tx_enable = 1'b1;
    frame(0, mk(8'h96), 12'h0, 10, 3, "t6a", fc, dc);
    repeat (300) @(negedge clock);
    chk("t6_reads_held", reads - r0, 1);
    chk("t6_tx_idle", tx, 1'b1);
    chk("t6_busy_idle", tx_busy, 1'b0);
    tx_enable = 1'b1;
    frame(0, mk(8'h5A), 12'h0, 10, -1, "t6b", fc, dc);
    chk("t6_reads", reads - r0, 2);

    // parity: 0x07 -> even parity bit 1, odd parity bit 0, 11-bit frame
    empty_p = 1'b0;
    en_p = 1'b1;
    n = 0;
    while (read_e !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk_rng("t5_read_wait", n, 0, 49);
    empty_p = 1'b1;
    frame(1, 12'hE0E, 12'hC0E, 11, -1, "t5", fc, dc);

    chk("underflow", underflow, 0);
    chk("read_width", max_run, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
